demux_channel_scheduler: RTL

DEMUX_CHANNEL_SCHEDULER -- requirements
Module: demux_channel_scheduler

---
 rtl/demux_channel_scheduler_if.sv | 36 +++
 rtl/demux_channel_scheduler.sv | 117 +++++++++++
 2 files changed

// File: rtl/demux_channel_scheduler_if.sv
// Bus bundle for demux_channel_scheduler: source handshake, routing controls and the
// shared one-hot sink side. drop_cnt exists only when DEMUX_SCHED_DROP_CNT_EN is defined.
interface demux_channel_scheduler_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        ch_en;
    logic              mode;
    logic [1:0]        in_sel;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [1:0]        cur_ch;
    logic              busy;
`ifdef DEMUX_SCHED_DROP_CNT_EN
    logic [7:0]        drop_cnt;
`endif

    modport master (
`ifdef DEMUX_SCHED_DROP_CNT_EN
        input  drop_cnt,
`endif
        output in_data, in_valid, ch_en, mode, in_sel, out_ready,
        input  in_ready, out_data, out_valid, cur_ch, busy
    );

    modport slave (
`ifdef DEMUX_SCHED_DROP_CNT_EN
        output drop_cnt,
`endif
        input  in_data, in_valid, ch_en, mode, in_sel, out_ready,
        output in_ready, out_data, out_valid, cur_ch, busy
    );
endinterface

// File: rtl/demux_channel_scheduler.sv
// Single-entry demultiplexing scheduler: routes each source word to one of four channels
// (round-robin or fixed select). Optional saturating drop counter via DEMUX_SCHED_DROP_CNT_EN.
module demux_channel_scheduler #(
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    demux_channel_scheduler_if.slave  bus
);
    localparam int NUM_CH = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e              state_q,  state_d;
    logic [DATA_W-1:0]   data_q,   data_d;
    logic [NUM_CH-1:0]   valid_q,  valid_d;
    logic [1:0]          cur_ch_q, cur_ch_d;

    logic       deliver;
    logic       in_ready;
    logic       xfer;
    logic       discard;
    logic       load;
    logic [1:0] rr_pick;
    logic [1:0] target;
    logic [1:0] idx;
    logic       found;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rr_pick = cur_ch_q;
        found   = 1'b0;
        idx     = cur_ch_q;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = cur_ch_q + 2'(i);
            if (!found && bus.ch_en[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        deliver  = (state_q == HOLD) && ((valid_q & bus.out_ready) != '0);
        in_ready = rst && (bus.ch_en != '0) && ((state_q == EMPTY) || deliver);
        xfer     = bus.in_valid && in_ready;
        target   = bus.mode ? bus.in_sel : rr_pick;
        discard  = xfer && bus.mode && !bus.ch_en[bus.in_sel];
        load     = xfer && !discard;
    end

    // A load wins over the delivery that freed the slot, giving one word per cycle.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        valid_d  = valid_q;
        cur_ch_d = cur_ch_q;
        if (load) begin
            state_d = HOLD;
            data_d  = bus.in_data;
            valid_d = NUM_CH'(1) << target;
        end else if (deliver) begin
            state_d = EMPTY;
            valid_d = '0;
        end
        if (xfer && !bus.mode) begin
            cur_ch_d = target + 2'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= EMPTY;
            data_q   <= '0;
            valid_q  <= '0;
            cur_ch_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            cur_ch_q <= cur_ch_d;
        end
    end

`ifdef DEMUX_SCHED_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (discard && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`else
    // Discarded words leave no trace when the counter is compiled out.
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.cur_ch    = cur_ch_q;
    assign bus.busy      = (state_q == HOLD);
endmodule
